muldiv_seq: RTL and testbench
=============================

Name: muldiv_seq

Overview:
Multi-cycle RV32M/RV64M multiply/divide unit for the EX stage. It replaces the combinational mul/div datapath so that XLEN=64 and divide timing close at target frequency. The hazard unit stalls the pipeline while busy is high. The execution unit launches an operation with start and collects the registered result on done. A flush from the hazard unit, on a branch or jump taken, aborts any in-flight operation.

Parameters:
XLEN, 32, datapath width; legal values 32 and 64.
FAST_MUL, 0, 0 = iterative shift-add multiply; 1 = single-cycle array multiply with registered result.

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
start  input  1  launch request; sampled on the clock edge when accepted
op  input  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
w  input  1  RV64 word op (MULW/DIVW/DIVUW/REMW/REMUW); ignored when XLEN=32
rs1  input  XLEN  operand A (dividend or multiplicand)
rs2  input  XLEN  operand B (divisor or multiplier)
flush  input  1  abort the in-flight operation
busy  output  1  high while an accepted operation is in progress
done  output  1  one-cycle pulse; result is valid in the same cycle
rd  output  XLEN  result; held stable until the next done

Behaviour:
- State machine: IDLE, CALC, FIX, DONE. Reset (async) forces IDLE with busy=0, done=0, rd=0 and the iteration counter at 0.
- Acceptance: start is accepted in IDLE or DONE only, which allows back-to-back operations. start in CALC or FIX is ignored. busy = (state==CALC || state==FIX).
- Width: N = 32 when (w && XLEN==64), else N = XLEN.
  - W ops use operand bits [31:0], sign-extended for signed ops and zero-extended for unsigned ops.
  - The W-op result is sign-extended from bit 31 to XLEN.
  - MUL with w=1 is MULW: it returns the low 32 bits of the product, sign-extended.
- On acceptance:
  - Capture the absolute values of signed operands and the result sign.
  - Load counter = N.
  - MULHSU treats rs1 as signed and rs2 as unsigned.
- Transitions:
  - IDLE/DONE --start--> CALC, for the normal case.
  - CALC decrements the counter once per cycle, doing one restoring-divide step or one shift-add step. When the counter reaches 1, the next state is FIX.
  - FIX applies sign correction, selects the low/high product half or quotient/remainder, registers rd, then goes to DONE.
  - DONE asserts done for exactly one cycle. It returns to IDLE unless a new start is accepted.
- Latency, counted from the accepting edge to the cycle done is high:
  - Normal iterative operation: N+2 cycles.
  - FAST_MUL=1 multiply: skips CALC (IDLE->FIX), 2 cycles.
- Divide special cases skip CALC and go directly to DONE with latency 1:
  - Divisor==0: DIV/DIVU quotient = all ones (-1); REM/REMU remainder = dividend.
  - Signed overflow (dividend = most negative N-bit value, divisor = -1): quotient = dividend, remainder = 0.
  - W variants of both cases apply at 32 bits, then sign-extend.
- flush:
  - In any state, flush forces IDLE on the next edge with done=0; rd keeps its previous value.
  - When flush and start occur in the same cycle, flush wins and the start is dropped.
  - flush in the cycle done is high does not retract that done.
- reset asserted mid-operation: immediate IDLE with all outputs cleared; no done is produced.
- Operand inputs may change after acceptance without affecting the result, because all operands are captured internally.

Test Plan:
1. XLEN=32, DIV rs1=-7 (0xFFFFFFF9), rs2=2 -> done 34 cycles after start, rd=0xFFFFFFFD (-3). Repeat with REM -> rd=0xFFFFFFFF (-1).
2. XLEN=32, DIVU rs1=100, rs2=0 -> done after 1 cycle, rd=0xFFFFFFFF. REMU with the same operands -> rd=100. DIV rs1=0x80000000, rs2=0xFFFFFFFF -> rd=0x80000000. REM with the same operands -> rd=0.
3. XLEN=32, MULH rs1=0x80000000, rs2=0x80000000 -> rd=0x40000000. MULHU rs1=0xFFFFFFFF, rs2=0xFFFFFFFF -> rd=0xFFFFFFFE. MULHSU rs1=-1, rs2=0xFFFFFFFF -> rd=0xFFFFFFFF. Run each with FAST_MUL=0 (latency 34) and FAST_MUL=1 (latency 2).
4. XLEN=64, w=1: DIVW rs1=0x00000000_FFFFFFF8, rs2=2 -> rd=0xFFFFFFFF_FFFFFFFC after 34 cycles. MULW rs1=0x7FFFFFFF, rs2=2 -> rd=0xFFFFFFFF_FFFFFFFE.
5. Start DIVU 1000/3, then assert flush 5 cycles later -> busy falls on the next edge, no done, rd unchanged. Assert start while busy -> ignored. Assert start and flush in the same cycle -> no operation is launched.
6. Back-to-back: assert start again in the DONE cycle with MUL 6*7 -> second done carries rd=42, with no idle cycle between operations. Assert reset mid-CALC -> busy=0, done=0, rd=0 immediately (asynchronously).

Source files
------------

// File: rtl/muldiv_seq.sv
// Multi-cycle RV32M/RV64M multiply/divide unit: shift-add multiply, restoring
// divide, with a single-cycle array multiply option selected by FAST_MUL.
module muldiv_seq #(
  parameter int XLEN     = 32,
  parameter bit FAST_MUL = 1'b0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic            w,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] rd
);

  localparam int CW     = $clog2(XLEN) + 1;
  localparam int WSHIFT = XLEN - 32;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t            state, state_n;
  logic [CW-1:0]     cnt;
  logic [2:0]        op_r;
  logic              w_r;
  logic              res_neg;
  logic [2*XLEN-1:0] acc, mcand, acc_sum, prod;
  logic [XLEN-1:0]   mplier, quo, rem, dvsr;
  logic [XLEN:0]     rem_sh, rem_diff;

  logic            is_w, a_signed, b_signed, a_neg, b_neg;
  logic            div_zero, div_ovf, special, accept, res_neg_c;
  logic [XLEN-1:0] a_ext, b_ext, a_abs, b_abs, min_val, special_raw, special_res;
  logic [XLEN-1:0] mul_res, div_res, fix_res;

  function automatic logic [XLEN-1:0] wfix(input logic [XLEN-1:0] x, input logic is_word);
    return is_word ? XLEN'($signed(x[31:0])) : x;
  endfunction

  // Operand conditioning: word-op extension, magnitudes, result sign and the
  // divide cases that finish without iterating.
  always_comb begin
    is_w     = (XLEN == 64) && w;
    a_signed = (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
    b_signed = (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
    a_ext    = rs1;
    b_ext    = rs2;
    if (is_w) begin
      a_ext = a_signed ? XLEN'($signed(rs1[31:0])) : XLEN'(rs1[31:0]);
      b_ext = b_signed ? XLEN'($signed(rs2[31:0])) : XLEN'(rs2[31:0]);
    end
    a_neg     = a_signed && a_ext[XLEN-1];
    b_neg     = b_signed && b_ext[XLEN-1];
    a_abs     = a_neg ? -a_ext : a_ext;
    b_abs     = b_neg ? -b_ext : b_ext;
    res_neg_c = (op[2] && op[1]) ? a_neg : (a_neg ^ b_neg);
    min_val   = is_w ? {{(XLEN-31){1'b1}}, 31'd0} : {1'b1, {(XLEN-1){1'b0}}};
    div_zero  = op[2] && (b_ext == '0);
    div_ovf   = op[2] && !op[0] && (a_ext == min_val) && (b_ext == '1);
    special   = div_zero || div_ovf;
    if (div_zero)
      special_raw = op[1] ? a_ext : '1;
    else
      special_raw = op[1] ? '0 : a_ext;
    special_res = wfix(special_raw, is_w);
    accept      = start && !flush && ((state == IDLE) || (state == DONE));
  end

  always_comb begin
    rem_sh   = {rem, quo[XLEN-1]};
    rem_diff = rem_sh - {1'b0, dvsr};
    acc_sum  = acc + (mplier[0] ? mcand : '0);
    prod     = res_neg ? -acc : acc;
    if (op_r == 3'd0)
      mul_res = prod[XLEN-1:0];
    else
      mul_res = w_r ? XLEN'(prod[63:32]) : prod[2*XLEN-1:XLEN];
    if (op_r[1])
      div_res = res_neg ? -rem : rem;
    else
      div_res = res_neg ? -quo : quo;
    fix_res = wfix(op_r[2] ? div_res : mul_res, w_r);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Flush overrides every transition, including a start in the same cycle.
  always_comb begin
    state_n = state;
    case (state)
      IDLE, DONE: begin
        if (!accept)                    state_n = IDLE;
        else if (special)               state_n = DONE;
        else if (FAST_MUL && !op[2])    state_n = FIX;
        else                            state_n = CALC;
      end
      CALC:    if (cnt == CW'(1)) state_n = FIX;
      FIX:     state_n = DONE;
      default: state_n = IDLE;
    endcase
    if (flush) state_n = IDLE;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      op_r    <= '0;
      w_r     <= 1'b0;
      res_neg <= 1'b0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      quo     <= '0;
      rem     <= '0;
      dvsr    <= '0;
      rd      <= '0;
    end else if (accept) begin
      op_r    <= op;
      w_r     <= is_w;
      res_neg <= res_neg_c;
      cnt     <= is_w ? CW'(32) : CW'(XLEN);
      mcand   <= (2*XLEN)'(a_abs);
      mplier  <= b_abs;
      acc     <= FAST_MUL ? (2*XLEN)'(a_abs) * (2*XLEN)'(b_abs) : '0;
      // Word divides start with the 32-bit dividend at the top of the shifter.
      quo     <= is_w ? (a_abs << WSHIFT) : a_abs;
      rem     <= '0;
      dvsr    <= b_abs;
      if (special) rd <= special_res;
    end else if (state == CALC) begin
      cnt    <= cnt - CW'(1);
      acc    <= acc_sum;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      if (!rem_diff[XLEN]) begin
        rem <= rem_diff[XLEN-1:0];
        quo <= {quo[XLEN-2:0], 1'b1};
      end else begin
        rem <= rem_sh[XLEN-1:0];
        quo <= {quo[XLEN-2:0], 1'b0};
      end
    end else if ((state == FIX) && !flush) begin
      rd <= fix_res;
    end
  end

  assign busy = (state == CALC) || (state == FIX);
  assign done = (state == DONE);

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: three instances (32-bit iterative, 32-bit
// fast multiply, 64-bit iterative) share one expectation queue.
module tb_muldiv_seq;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  start_v = '0;
  logic [2:0]  w_v = '0;
  logic [2:0]  flush_v = '0;
  logic [2:0]  op_s [3];
  logic [63:0] rs1_s [3];
  logic [63:0] rs2_s [3];
  wire  [2:0]  busy_v, done_v;
  wire  [31:0] rd0, rd1;
  wire  [63:0] rd2;

  int cycle = 0;
  int n_assert = 0;
  int n_fail = 0;
  int tag = 0;
  int done_cnt [3];

  typedef struct {
    int          dut;
    logic [63:0] rd;
    int          cyc;
    int          id;
  } exp_t;

  exp_t sb [$];

  muldiv_seq #(.XLEN(32), .FAST_MUL(1'b0)) u_iter32 (
    .clock(clock), .reset(reset), .start(start_v[0]), .op(op_s[0]), .w(w_v[0]),
    .rs1(rs1_s[0][31:0]), .rs2(rs2_s[0][31:0]), .flush(flush_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .rd(rd0));

  muldiv_seq #(.XLEN(32), .FAST_MUL(1'b1)) u_fast32 (
    .clock(clock), .reset(reset), .start(start_v[1]), .op(op_s[1]), .w(w_v[1]),
    .rs1(rs1_s[1][31:0]), .rs2(rs2_s[1][31:0]), .flush(flush_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .rd(rd1));

  muldiv_seq #(.XLEN(64), .FAST_MUL(1'b0)) u_iter64 (
    .clock(clock), .reset(reset), .start(start_v[2]), .op(op_s[2]), .w(w_v[2]),
    .rs1(rs1_s[2]), .rs2(rs2_s[2]), .flush(flush_v[2]),
    .busy(busy_v[2]), .done(done_v[2]), .rd(rd2));

  always #5 clock = ~clock;

  always @(posedge clock) cycle <= cycle + 1;

  function automatic logic [63:0] rd_of(input int i);
    case (i)
      0:       return {32'd0, rd0};
      1:       return {32'd0, rd1};
      default: return rd2;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Pops the oldest expectation whenever any instance pulses done.
  always @(negedge clock) begin
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      if (done_v[i] === 1'b1) begin
        done_cnt[i]++;
        if (sb.size() == 0 || sb[0].dut != i) begin
          n_assert++;
          n_fail++;
          $display("[TB] FAIL unexpected_done dut%0d: got done with rd=0x%0h, expected no done", i, rd_of(i));
        end else begin
          e = sb.pop_front();
          checkOutput($sformatf("op%0d_rd", e.id), rd_of(i), e.rd);
          checkOutput($sformatf("op%0d_latency", e.id), 64'(cycle), 64'(e.cyc));
        end
      end
    end
  end

  // Issues one start pulse at a negedge; scrambles operands afterwards.
  task automatic applyStimulus(input int d, input logic [2:0] o, input logic ww,
                               input logic [63:0] a, input logic [63:0] b,
                               input logic [63:0] exp_rd, input int lat, input bit expect_done);
    exp_t e;
    op_s[d]    = o;
    w_v[d]     = ww;
    rs1_s[d]   = a;
    rs2_s[d]   = b;
    start_v[d] = 1'b1;
    if (expect_done) begin
      e.dut = d;
      e.rd  = exp_rd;
      e.cyc = cycle + lat;
      e.id  = tag;
      tag++;
      sb.push_back(e);
    end
    @(negedge clock);
    start_v[d] = 1'b0;
    op_s[d]    = 3'($urandom);
    rs1_s[d]   = {$urandom, $urandom};
    rs2_s[d]   = {$urandom, $urandom};
  endtask

  task automatic waitDrain(input int budget);
    int n = 0;
    while (sb.size() > 0 && n < budget) begin
      @(negedge clock);
      n++;
    end
    checkOutput("drain_pending", 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  task automatic runOp(input int d, input logic [2:0] o, input logic ww,
                       input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] exp_rd, input int lat);
    applyStimulus(d, o, ww, a, b, exp_rd, lat, 1'b1);
    waitDrain(lat + 10);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int dc;
    int n;
    for (int i = 0; i < 3; i++) begin
      op_s[i] = '0; rs1_s[i] = '0; rs2_s[i] = '0; done_cnt[i] = 0;
    end
    repeat (2) @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("reset_busy%0d", i), 64'(busy_v[i]), 64'd0);
      checkOutput($sformatf("reset_done%0d", i), 64'(done_v[i]), 64'd0);
      checkOutput($sformatf("reset_rd%0d", i), rd_of(i), 64'd0);
    end
    reset = 1'b0;
    @(negedge clock);

    // 32-bit iterative: signed divide, divide specials, multiply high halves
    runOp(0, 3'd4, 1'b0, 64'hFFFFFFF9, 64'd2,        64'hFFFFFFFD, 34);
    runOp(0, 3'd6, 1'b0, 64'hFFFFFFF9, 64'd2,        64'hFFFFFFFF, 34);
    runOp(0, 3'd5, 1'b0, 64'd100,      64'd0,        64'hFFFFFFFF, 1);
    runOp(0, 3'd7, 1'b0, 64'd100,      64'd0,        64'd100,      1);
    runOp(0, 3'd4, 1'b0, 64'h80000000, 64'hFFFFFFFF, 64'h80000000, 1);
    runOp(0, 3'd6, 1'b0, 64'h80000000, 64'hFFFFFFFF, 64'd0,        1);
    runOp(0, 3'd1, 1'b0, 64'h80000000, 64'h80000000, 64'h40000000, 34);
    runOp(0, 3'd3, 1'b0, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFE, 34);
    runOp(0, 3'd2, 1'b0, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFF, 34);
    runOp(0, 3'd0, 1'b0, 64'hFFFFFFFD, 64'd7,        64'hFFFFFFEB, 34);
    runOp(0, 3'd7, 1'b0, 64'd1000,     64'd7,        64'd6,        34);

    // 32-bit fast multiply; divides still iterate
    runOp(1, 3'd1, 1'b0, 64'h80000000, 64'h80000000, 64'h40000000, 2);
    runOp(1, 3'd3, 1'b0, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFE, 2);
    runOp(1, 3'd2, 1'b0, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFF, 2);
    runOp(1, 3'd0, 1'b0, 64'd6,        64'd7,        64'd42,       2);
    runOp(1, 3'd4, 1'b0, 64'hFFFFFFF9, 64'd2,        64'hFFFFFFFD, 34);

    // 64-bit: word ops, word specials, full-width ops
    runOp(2, 3'd4, 1'b1, 64'h00000000_FFFFFFF8, 64'd2, 64'hFFFFFFFF_FFFFFFFC, 34);
    runOp(2, 3'd0, 1'b1, 64'h7FFFFFFF, 64'd2,          64'hFFFFFFFF_FFFFFFFE, 34);
    runOp(2, 3'd5, 1'b1, 64'd5, 64'hFFFFFFFF_00000000, 64'hFFFFFFFF_FFFFFFFF, 1);
    runOp(2, 3'd7, 1'b1, 64'h00000001_80000000, 64'd0, 64'hFFFFFFFF_80000000, 1);
    runOp(2, 3'd4, 1'b1, 64'h00000000_80000000, 64'h00000000_FFFFFFFF, 64'hFFFFFFFF_80000000, 1);
    runOp(2, 3'd6, 1'b1, 64'h00000000_80000000, 64'h00000000_FFFFFFFF, 64'd0, 1);
    runOp(2, 3'd3, 1'b0, 64'hFFFFFFFF_FFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 64'hFFFFFFFF_FFFFFFFE, 66);
    runOp(2, 3'd4, 1'b0, 64'hFFFFFFFF_FFFFFF9C, 64'd7, 64'hFFFFFFFF_FFFFFFF2, 66);
    runOp(2, 3'd6, 1'b0, 64'hFFFFFFFF_FFFFFF9C, 64'd7, 64'hFFFFFFFF_FFFFFFFE, 66);

    // A start while busy must not disturb the running divide
    applyStimulus(0, 3'd5, 1'b0, 64'd1000, 64'd7, 64'd142, 34, 1'b1);
    repeat (5) @(negedge clock);
    start_v[0] = 1'b1; op_s[0] = 3'd0; rs1_s[0] = 64'd5; rs2_s[0] = 64'd5;
    @(negedge clock);
    start_v[0] = 1'b0;
    waitDrain(60);

    // Flush mid-divide: busy drops, no done, rd keeps 142
    applyStimulus(0, 3'd5, 1'b0, 64'd1000, 64'd3, 64'd0, 0, 1'b0);
    checkOutput("busy_during_calc", 64'(busy_v[0]), 64'd1);
    repeat (4) @(negedge clock);
    flush_v[0] = 1'b1;
    dc = done_cnt[0];
    @(negedge clock);
    flush_v[0] = 1'b0;
    checkOutput("flush_busy", 64'(busy_v[0]), 64'd0);
    repeat (40) @(negedge clock);
    checkOutput("flush_no_done", 64'(done_cnt[0] - dc), 64'd0);
    checkOutput("flush_rd_kept", rd_of(0), 64'd142);

    // Start and flush together: nothing launches
    start_v[0] = 1'b1; flush_v[0] = 1'b1; op_s[0] = 3'd5; rs1_s[0] = 64'd9; rs2_s[0] = 64'd2;
    dc = done_cnt[0];
    @(negedge clock);
    start_v[0] = 1'b0; flush_v[0] = 1'b0;
    checkOutput("start_flush_busy", 64'(busy_v[0]), 64'd0);
    repeat (40) @(negedge clock);
    checkOutput("start_flush_no_done", 64'(done_cnt[0] - dc), 64'd0);

    // Back-to-back: second start issued in the done cycle of the first
    applyStimulus(0, 3'd0, 1'b0, 64'd3, 64'd5, 64'd15, 34, 1'b1);
    n = 0;
    while (done_v[0] !== 1'b1 && n < 60) begin
      @(negedge clock);
      n++;
    end
    checkOutput("b2b_first_done_seen", 64'(done_v[0]), 64'd1);
    applyStimulus(0, 3'd0, 1'b0, 64'd6, 64'd7, 64'd42, 34, 1'b1);
    waitDrain(60);

    // Asynchronous reset in the middle of CALC
    applyStimulus(0, 3'd4, 1'b0, 64'hFFFFFFF9, 64'd2, 64'd0, 0, 1'b0);
    repeat (10) @(negedge clock);
    @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_reset_busy", 64'(busy_v[0]), 64'd0);
    checkOutput("async_reset_done", 64'(done_v[0]), 64'd0);
    checkOutput("async_reset_rd", rd_of(0), 64'd0);
    dc = done_cnt[0];
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (40) @(negedge clock);
    checkOutput("async_reset_no_done", 64'(done_cnt[0] - dc), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
